// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with runtime pattern load
// Optional saturating match counter (port match_cnt) enabled by defining SEQDET_CNT_EN.
module seq_detect_param #(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1011,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             dout
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               dout_q, dout_d;
  logic [PAT_W-1:0]   win;
  logic               hit;

  assign win = {hist_q[PAT_W-2:0], din};
  // A match needs PAT_W-1 valid older bits plus the bit arriving on this edge.
  assign hit = din_en && !pat_load && (fill_q >= FILL_LAST) && (win == pat_q);

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    dout_d  = 1'b0;
    state_d = state_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (din_en) begin
      hist_d = win;
      if (hit) begin
        dout_d = 1'b1;
        fill_d = overlap ? FILL_FULL : '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
    if (fill_d == '0) begin
      state_d = IDLE;
    end else if (fill_d == FILL_FULL) begin
      state_d = ARMED;
    end else begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PAT_DEFAULT;
      hist_q  <= '0;
      fill_q  <= '0;
      dout_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      state_q <= state_d;
    end
  end

  assign dout = dout_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pat_load) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed and randomized bench for seq_detect_param
// Reference model keeps the list of valid bits since the last reset/load/non-overlap match.
module tb_seq_detect_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_en = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             pat_load = 1'b0;
  logic             overlap = 1'b0;
  logic             dout;
`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [PAT_W-1:0] m_pat;
  int               m_bits[$];
  logic             m_dout;
  int               m_cnt;

  seq_detect_param #(
    .PAT_W(PAT_W),
    .PAT_DEFAULT(4'b1011),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_en(din_en),
    .pat_in(pat_in),
    .pat_load(pat_load),
    .overlap(overlap),
    .dout(dout)
`ifdef SEQDET_CNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic ld, input logic [PAT_W-1:0] pi,
                            input logic en, input logic d, input logic ov);
    bit hit;
    if (r) begin
      m_pat = 4'b1011;
      m_bits.delete();
      m_dout = 1'b0;
      m_cnt = 0;
    end else if (ld) begin
      m_pat = pi;
      m_bits.delete();
      m_dout = 1'b0;
      m_cnt = 0;
    end else if (en) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      hit = (m_bits.size() == PAT_W);
      for (int i = 0; i < PAT_W; i++) begin
        if (hit && (m_bits[i] != int'(m_pat[PAT_W-1-i]))) hit = 1'b0;
      end
      m_dout = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!ov) m_bits.delete();
      end
    end else begin
      m_dout = 1'b0;
    end
  endtask

  // One clock: drive after the falling edge, sample on the next falling edge.
  // exp < 0 means only the reference model is consulted.
  task automatic cyc(input string tag, input logic r, input logic ld, input logic [PAT_W-1:0] pi,
                     input logic en, input logic d, input logic ov, input int exp);
    rst = r; pat_load = ld; pat_in = pi; din_en = en; din = d; overlap = ov;
    @(posedge clk);
    model_edge(r, ld, pi, en, d, ov);
    @(negedge clk);
    checks++;
    assert (dout === m_dout) else begin
      failures++;
      $error("FAIL %s_model dout observed=%0b expected=%0b", tag, dout, m_dout);
    end
    if (exp >= 0) begin
      checks++;
      assert (dout === exp[0]) else begin
        failures++;
        $error("FAIL %s dout observed=%0b expected=%0d", tag, dout, exp);
      end
    end
`ifdef SEQDET_CNT_EN
    checks++;
    assert (int'(match_cnt) === m_cnt) else begin
      failures++;
      $error("FAIL %s_cnt match_cnt observed=%0d expected=%0d", tag, match_cnt, m_cnt);
    end
`endif
  endtask

  task automatic bits(input string tag, input logic ov, input int n, input logic [31:0] b,
                      input logic [31:0] e);
    for (int i = n - 1; i >= 0; i--) cyc(tag, 1'b0, 1'b0, 4'b0, 1'b1, b[i], ov, int'(e[i]));
  endtask

  initial begin
    m_pat = 4'b1011;
    m_dout = 1'b0;
    m_cnt = 0;
    @(negedge clk);

    cyc("reset", 1'b1, 1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc("reset_hold", 1'b1, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1, 0);
    bits("basic", 1'b0, 4, 32'b1011, 32'b0001);
    cyc("basic_after", 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0, 0);

    cyc("rst", 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 0);
    bits("ovl1", 1'b1, 7, 32'b1011011, 32'b0001001);
    cyc("rst", 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 0);
    bits("ovl0", 1'b0, 7, 32'b1011011, 32'b0001000);

    cyc("rst", 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 0);
    bits("gap_a", 1'b0, 2, 32'b10, 32'b00);
    for (int i = 0; i < 3; i++) cyc("gap", 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0, 0);
    bits("gap_b", 1'b0, 2, 32'b11, 32'b01);

    cyc("rst", 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 0);
    bits("load_pre", 1'b1, 3, 32'b101, 32'b000);
    cyc("load", 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 0);
    bits("load_zeros", 1'b1, 5, 32'b00000, 32'b00011);

    cyc("rst", 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 0);
    bits("mid_pre", 1'b0, 3, 32'b101, 32'b000);
    cyc("mid_rst", 1'b1, 1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 0);
    bits("mid_post", 1'b0, 5, 32'b11011, 32'b00001);

    cyc("rst_ld", 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    bits("rst_ld_zeros", 1'b0, 4, 32'b0000, 32'b0000);
    bits("rst_ld_dflt", 1'b0, 4, 32'b1011, 32'b0001);

`ifdef SEQDET_CNT_EN
    cyc("sat_load", 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 1; i <= 259; i++) cyc("sat", 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1, (i >= 4) ? 1 : 0);
    checks++;
    assert (match_cnt === 8'd255) else begin
      failures++;
      $error("FAIL sat_value match_cnt observed=%0d expected=255", match_cnt);
    end
    cyc("sat_clear", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 0);
    checks++;
    assert (match_cnt === 8'd0) else begin
      failures++;
      $error("FAIL sat_clear_value match_cnt observed=%0d expected=0", match_cnt);
    end
`endif

    for (int i = 0; i < 2000; i++) begin
      logic             r, ld, en, d, ov;
      logic [PAT_W-1:0] pi;
      int               sel;
      r  = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      ov = $urandom_range(0, 1);
      sel = $urandom_range(0, 4);
      case (sel)
        0: pi = 4'b0000;
        1: pi = 4'b1111;
        2: pi = 4'b1011;
        3: pi = 4'b0101;
        default: pi = PAT_W'($urandom);
      endcase
      cyc("rand", r, ld, pi, en, d, ov, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the generalised successor to our fixed three-bit "101" detector. Samples a 1-bit serial stream on qualified clock edges and compares a PAT_W-bit sliding window against a runtime-loadable pattern. Emits a one-cycle registered match pulse, with overlapping or non-overlapping detection selected at run time. Sits in the serial front end, between the bit-slicer and the framing/control logic.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..32
- PAT_DEFAULT, 4'b1011, pattern loaded at reset; PAT_W bits wide
- CNT_W, 8, width of the match counter; used only when SEQDET_CNT_EN is defined
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous and active-high
- din  in  1  serial data bit
- din_en  in  1  sample qualifier; din is consumed only on edges where din_en=1
- pat_in  in  PAT_W  new pattern value
- pat_load  in  1  loads pat_in as the active pattern on this edge
- overlap  in  1  1 = overlapping detection; 0 = non-overlapping detection
- dout  out  1  registered match pulse
- match_cnt  out  CNT_W  saturating match count; port present only with SEQDET_CNT_EN

## Operation
- Internal registers:
  - pat: active pattern.
  - hist: PAT_W-bit history; newest bit in hist[0].
  - fill: valid-bit count, 0..PAT_W.
  - state: FSM state.
- FSM states:
  - IDLE: fill=0.
  - FILL: 0<fill<PAT_W.
  - ARMED: fill=PAT_W.
- Edge priority: rst > pat_load > din_en.
- rst: pat<=PAT_DEFAULT, hist<=0, fill<=0, state<=IDLE, dout<=0, match_cnt<=0.
- pat_load=1 (rst=0):
  - pat<=pat_in, hist<=0, fill<=0, state<=IDLE, dout<=0, match_cnt<=0.
  - din is ignored on that edge even if din_en=1.
- din_en=1 (no rst, no pat_load):
  - win={hist[PAT_W-2:0],din}; hist<=win.
  - A match occurs when fill>=PAT_W-1 and win==pat.
  - On a match: dout<=1.
    - overlap=1: fill<=PAT_W, state<=ARMED.
    - overlap=0: fill<=0, state<=IDLE; the next match needs PAT_W fresh bits.
  - No match: dout<=0, fill<=min(fill+1,PAT_W), state follows fill.
- din_en=0: hist, fill and state hold; dout<=0.
- overlap may change on any edge; it takes effect at the next match decision.
- pat changes only via rst or pat_load; pat_in is ignored otherwise.

## Timing
- Comparison is combinational on win. dout is a flop.
- Latency: dout is high for exactly the one cycle following the rising edge that sampled the final pattern bit.
- Back-to-back matches (overlap=1, e.g. pattern all-ones) give dout held high across consecutive qualified edges, one cycle per match.
- Reset value of every output: dout=0, match_cnt=0.
- Reset or pat_load mid-sequence discards all partial history; no match is possible until PAT_W new qualified bits have been sampled.
- rst and pat_load asserted together: reset wins, pat=PAT_DEFAULT.

## Configuration
- SEQDET_CNT_EN defined:
  - Port match_cnt exists.
  - It increments on every edge that sets dout<=1 and saturates at 2^CNT_W-1 (no wrap).
  - It is cleared by rst and pat_load.
- Undefined: no match_cnt port and no counter logic; all other behaviour is identical.

## Test plan
Defaults: PAT_W=4, pattern 1011. din and din_en change at the falling edge.
- Basic detect: rst, then din 1,0,1,1 with din_en=1 -> dout=1 for one cycle after the 4th sampling edge; dout=0 at every other cycle, including during reset.
- Overlap vs non-overlap on stream 1,0,1,1,0,1,1:
  - overlap=1 -> two pulses, after bits 4 and 7.
  - overlap=0 -> one pulse, after bit 4 only.
- Qualifier gaps: 1,0,(din_en=0 for 3 cycles, din=1),1,1 -> one pulse after the final 1; no pulse during the gap.
- Runtime load: after 1,0,1, pat_load with pat_in=4'b0000 and overlap=1, then din 0×5 -> no pulse on the first three bits; pulses after the 4th and 5th bits.
- Mid-sequence reset: 1,0,1, then rst for 1 cycle, then 1 -> no pulse; a later 1,0,1,1 pulses, confirming pat=1011.
- SEQDET_CNT_EN with CNT_W=8: pat_load 4'b1111, overlap=1, 259 ones -> 256 matches; match_cnt saturates at 255; a subsequent pat_load clears it to 0.
